// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared constants and the prefetch entry type for the
// instruction fetch front-end.
//   ADDR_W / DATA_W : default PC and instruction widths
//   RESET_PC        : default PC loaded on reset
//   fetch_entry_t   : one prefetched {pc, instr} pair
package ifetch_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam logic [ADDR_W-1:0] RESET_PC = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage : ifetch_pkg

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: synchronous prefetch FIFO of fetch_entry_t.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   push, push_entry : enqueue push_entry at the tail
//   pop           : dequeue the head (caller guarantees count != 0)
//   flush         : synchronous empty; wins over push and pop
//   count         : occupancy, $clog2(DEPTH)+1 bits
//   head          : entry at the head, read straight from storage flops
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  fetch_entry_t       push_entry,
  input  logic               pop,
  input  logic               flush,
  output logic [CNT_W-1:0]   count,
  output fetch_entry_t       head
);

  fetch_entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is cleared on reset on purpose: the head outputs must read
  // zero after reset, and with only DEPTH entries the reset fan-out is small.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push && !flush) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  // A full FIFO pushing and popping together overwrites the slot being
  // popped; the head read below still sees the pre-edge contents.
  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule : ifetch_fifo

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch front-end. Owns the PC, reads the
// word-indexed instruction memory combinationally and queues {pc, instr}
// pairs into a prefetch FIFO drained by decode via valid/ready.
// Optional build macro IFETCH_PERF_EN adds perf_fetch_cnt / perf_stall_cnt.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   instr_addr        : word index into instruction memory (= PC)
//   instruction       : memory read data for instr_addr, same cycle
//   redirect_valid/pc : load a new PC and flush the FIFO
//   out_valid/ready   : decode handshake on the FIFO head
//   out_instr, out_pc : head instruction and its PC (registered storage)
//   perf_fetch_cnt    : pushes since reset (IFETCH_PERF_EN only)
//   perf_stall_cnt    : cycles with out_valid && !out_ready (IFETCH_PERF_EN only)
// ADDR_W / DATA_W must match the widths of ifetch_pkg::fetch_entry_t.
module instr_fetch #(
  parameter int unsigned             ADDR_W   = ifetch_pkg::ADDR_W,
  parameter int unsigned             DATA_W   = ifetch_pkg::DATA_W,
  parameter logic [ADDR_W-1:0]       RESET_PC = ifetch_pkg::RESET_PC,
  parameter int unsigned             DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic [DATA_W-1:0] instruction,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0]        pc_q, pc_d;
  logic                     push, pop;
  logic [CNT_W-1:0]         count;
  ifetch_pkg::fetch_entry_t push_entry, head;

  // A redirect cycle hides the head so decode never accepts an entry that is
  // about to be flushed.
  assign out_valid = (count != '0) && !redirect_valid;
  assign pop       = out_valid && out_ready;
  // A full FIFO can still accept a fetch when the head leaves this cycle.
  assign push      = !rst && !redirect_valid &&
                     ((count < CNT_W'(DEPTH)) || pop);

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) pc_d = redirect_pc;
    else if (push)      pc_d = pc_q + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  assign instr_addr = pc_q;

  always_comb begin
    push_entry       = '0;
    push_entry.pc    = pc_q;
    push_entry.instr = instruction;
  end

  ifetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .count      (count),
    .head       (head)
  );

  assign out_pc    = head.pc;
  assign out_instr = head.instr;

`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Both counters wrap silently.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q + (push ? 32'd1 : 32'd0);
    stall_cnt_d = stall_cnt_q + ((out_valid && !out_ready) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  // No performance counters in this build.
`endif

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed self-checking bench for instr_fetch.
// Cycle numbering: cycle 0 is the first cycle with rst low; "tick" advances
// one rising edge and samples 2 time units after it.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_addr;
  logic [31:0] instruction;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .instr_addr     (instr_addr),
    .instruction    (instruction),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  // Instruction memory contents: words 0..7 hold fixed encodings, any other
  // address reads 0xDEAD in the top half and the low address bits below.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h0000_0013;
      32'd1:   return 32'h0010_0093;
      32'd2:   return 32'h0020_0113;
      32'd3:   return 32'h0030_0193;
      32'd4:   return 32'h0040_0213;
      32'd5:   return 32'h0050_0293;
      32'd6:   return 32'h0060_0313;
      32'd7:   return 32'h0070_0393;
      default: return {16'hDEAD, a[15:0]};
    endcase
  endfunction

  always_comb instruction = mem_word(instr_addr);

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  // Two reset cycles, then release; returns inside cycle 0.
  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    settle();
  endtask

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b1;

    // ---- reset state ----
    tick();
    tick();
    settle();
    check("rst_out_valid",  {31'd0, out_valid}, 32'd0);
    check("rst_instr_addr", instr_addr, 32'd0);
    check("rst_out_pc",     out_pc,     32'd0);
    check("rst_out_instr",  out_instr,  32'd0);
`ifdef IFETCH_PERF_EN
    check("rst_perf_fetch", perf_fetch_cnt, 32'd0);
    check("rst_perf_stall", perf_stall_cnt, 32'd0);
`endif

    // ---- streaming after reset release ----
    rst = 1'b0;
    settle();
    check("c0_instr_addr", instr_addr, 32'd0);
    check("c0_out_valid",  {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("stream_valid", {31'd0, out_valid}, 32'd1);
      check("stream_pc",    out_pc,    32'(i));
      check("stream_instr", out_instr, mem_word(32'(i)));
    end

    // ---- stall fill, then drain in order ----
    out_ready = 1'b0;
    do_reset();
    tick();                                   // cycle 1
    check("fill_c1_valid", {31'd0, out_valid}, 32'd1);
    check("fill_c1_addr",  instr_addr, 32'd1);
    for (int c = 2; c <= 5; c++) begin
      tick();
      check("fill_hold_addr", instr_addr, 32'd2);
      check("fill_hold_pc",   out_pc,     32'd0);
    end
    tick();                                   // cycle 6
    out_ready = 1'b1;
    settle();
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", {31'd0, out_valid}, 32'd1);
      check("drain_pc",    out_pc,    32'(i));
      check("drain_instr", out_instr, mem_word(32'(i)));
      tick();
    end

    // ---- redirect with FIFO full ----
    out_ready = 1'b0;
    do_reset();
    tick();
    tick();
    tick();                                   // cycle 3, FIFO full
    redirect_valid = 1'b1;
    redirect_pc    = 32'd5;
    settle();
    check("redir_n_valid", {31'd0, out_valid}, 32'd0);
    tick();                                   // N+1
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    settle();
    check("redir_n1_valid", {31'd0, out_valid}, 32'd0);
    check("redir_n1_addr",  instr_addr, 32'd5);
    tick();                                   // N+2
    check("redir_n2_valid", {31'd0, out_valid}, 32'd1);
    check("redir_n2_pc",    out_pc,    32'd5);
    check("redir_n2_instr", out_instr, mem_word(32'd5));
    tick();
    check("redir_next_pc",  out_pc,    32'd6);

    // ---- back-to-back redirects: last one wins ----
    redirect_valid = 1'b1;
    redirect_pc    = 32'd3;
    settle();
    check("b2b_valid0", {31'd0, out_valid}, 32'd0);
    tick();
    redirect_pc = 32'd6;
    tick();
    redirect_valid = 1'b0;
    settle();
    check("b2b_addr",   instr_addr, 32'd6);
    check("b2b_valid1", {31'd0, out_valid}, 32'd0);
    tick();
    check("b2b_pc0",    out_pc,    32'd6);
    check("b2b_instr0", out_instr, mem_word(32'd6));
    tick();
    check("b2b_pc1",    out_pc,    32'd7);

    // ---- wrap from all-ones ----
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    tick();
    check("wrap_pc0",    out_pc,    32'hFFFF_FFFF);
    check("wrap_instr0", out_instr, 32'hDEAD_FFFF);
    tick();
    check("wrap_pc1",    out_pc,    32'h0000_0000);
    check("wrap_instr1", out_instr, mem_word(32'd0));

    // ---- reset beats redirect ----
    rst            = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'd4;
    tick();
    tick();
    rst            = 1'b0;
    redirect_valid = 1'b0;
    settle();
    check("rstredir_addr", instr_addr, 32'd0);
    tick();
    check("rstredir_valid", {31'd0, out_valid}, 32'd1);
    check("rstredir_pc",    out_pc, 32'd0);

`ifdef IFETCH_PERF_EN
    // ---- performance counters: 4 stalled cycles, then 10 streaming ----
    out_ready = 1'b0;
    do_reset();
    check("perf_fetch_zero", perf_fetch_cnt, 32'd0);
    check("perf_stall_zero", perf_stall_cnt, 32'd0);
    for (int c = 0; c < 4; c++) tick();       // pushes in c0,c1; stalls c1..c3
    check("perf_fetch_fill", perf_fetch_cnt, 32'd2);
    check("perf_stall_fill", perf_stall_cnt, 32'd3);
    out_ready = 1'b1;
    settle();
    for (int c = 0; c < 10; c++) tick();
    check("perf_fetch_total", perf_fetch_cnt, 32'd12);
    check("perf_stall_total", perf_stall_cnt, 32'd3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_instr_fetch
